// File: rtl/lookup_hold_queue.sv
// Packet holding queue for the output-port-lookup stage: buffers whole packets until
// their out-of-band lookup result arrives, then forwards (IOQ port bitmap patched) or drops.
module lookup_hold_queue #(
  parameter int         DATA_WIDTH        = 64,
  parameter int         CTRL_WIDTH        = DATA_WIDTH / 8,
  parameter int         NUM_OUTPUT_QUEUES = 8,
  parameter int         DEPTH_BITS        = 9,
  parameter int         MAX_PKTS_BITS     = 4,
  parameter logic [7:0] IOQ_STAGE_NUM     = 8'hFF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [CTRL_WIDTH-1:0]        in_ctrl,
  input  logic                         in_wr,
  output logic                         in_rdy,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CTRL_WIDTH-1:0]        out_ctrl,
  output logic                         out_wr,
  input  logic                         out_rdy,
  input  logic                         lookup_valid,
  input  logic [NUM_OUTPUT_QUEUES-1:0] lookup_dst_ports,
  input  logic                         lookup_drop,
  output logic                         lookup_overflow,
  output logic [31:0]                  pkts_forwarded,
  output logic [31:0]                  pkts_dropped
);
  localparam int BUF_W = 1 + CTRL_WIDTH + DATA_WIDTH;
  localparam int RES_W = 1 + NUM_OUTPUT_QUEUES;
  localparam logic [DEPTH_BITS:0]    BUF_DEPTH = {1'b1, {DEPTH_BITS{1'b0}}};
  localparam logic [MAX_PKTS_BITS:0] MAX_PKTS  = {1'b1, {MAX_PKTS_BITS{1'b0}}};
  localparam logic [CTRL_WIDTH-1:0]  IOQ_CTRL  = CTRL_WIDTH'(IOQ_STAGE_NUM);

  typedef enum logic {T_HDR, T_PAYLOAD} in_state_t;
  typedef enum logic [1:0] {O_IDLE, O_FWD, O_DROP} out_state_t;

  // Word buffer
  logic [BUF_W-1:0]      buf_mem [0:(1<<DEPTH_BITS)-1];
  logic [DEPTH_BITS:0]   buf_wr_ptr, buf_rd_ptr, buf_count, buf_free;
  logic                  buf_empty, buf_pop;
  logic [BUF_W-1:0]      head;
  logic                  head_eop;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic [DATA_WIDTH-1:0] head_data;

  // Input tracking
  in_state_t              in_state;
  logic                   pkt_started, in_accept, in_eop, pkt_first, ready_q;
  logic [MAX_PKTS_BITS:0] pif;

  // Result queue
  logic [RES_W-1:0]       rq_mem [0:(1<<MAX_PKTS_BITS)-1];
  logic [MAX_PKTS_BITS:0] rq_wr_ptr, rq_rd_ptr, rq_count;
  logic                   rq_empty, rq_full, rq_push, rq_pop;
  logic [RES_W-1:0]       rq_head;

  // Output side
  out_state_t                   state, state_next;
  logic                         emit, patch, ioq_done, pop_eop;
  logic [NUM_OUTPUT_QUEUES-1:0] cur_dst;

  assign buf_count = buf_wr_ptr - buf_rd_ptr;
  assign buf_free  = BUF_DEPTH - buf_count;
  assign buf_empty = (buf_count == '0);
  assign head      = buf_mem[buf_rd_ptr[DEPTH_BITS-1:0]];
  assign head_eop  = head[BUF_W-1];
  assign head_ctrl = head[DATA_WIDTH +: CTRL_WIDTH];
  assign head_data = head[DATA_WIDTH-1:0];

  assign in_rdy    = ready_q && (buf_free >= (DEPTH_BITS+1)'(2)) && (pkt_started || (pif < MAX_PKTS));
  assign in_accept = in_wr && in_rdy;
  assign in_eop    = (in_state == T_PAYLOAD) && (in_ctrl != '0);
  assign pkt_first = in_accept && !pkt_started;

  assign rq_count  = rq_wr_ptr - rq_rd_ptr;
  assign rq_empty  = (rq_count == '0);
  assign rq_full   = (rq_count == MAX_PKTS);
  assign rq_head   = rq_mem[rq_rd_ptr[MAX_PKTS_BITS-1:0]];
  assign rq_push   = lookup_valid && (!rq_full || rq_pop);
  assign pop_eop   = buf_pop && head_eop;

  always_ff @(posedge clk) begin
    if (in_accept) buf_mem[buf_wr_ptr[DEPTH_BITS-1:0]] <= {in_eop, in_ctrl, in_data};
    if (rq_push)   rq_mem[rq_wr_ptr[MAX_PKTS_BITS-1:0]] <= {lookup_drop, lookup_dst_ports};
  end

  // The tracker marks the first non-zero ctrl word after payload as end of packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_state    <= T_HDR;
      pkt_started <= 1'b0;
      buf_wr_ptr  <= '0;
      ready_q     <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (in_accept) begin
        buf_wr_ptr <= buf_wr_ptr + 1'b1;
        if (in_eop) begin
          in_state    <= T_HDR;
          pkt_started <= 1'b0;
        end else begin
          pkt_started <= 1'b1;
          if (in_ctrl == '0) in_state <= T_PAYLOAD;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pif             <= '0;
      rq_wr_ptr       <= '0;
      rq_rd_ptr       <= '0;
      buf_rd_ptr      <= '0;
      lookup_overflow <= 1'b0;
    end else begin
      case ({pkt_first, pop_eop})
        2'b10:   pif <= pif + 1'b1;
        2'b01:   pif <= pif - 1'b1;
        default: pif <= pif;
      endcase
      if (rq_push) rq_wr_ptr <= rq_wr_ptr + 1'b1;
      if (rq_pop)  rq_rd_ptr <= rq_rd_ptr + 1'b1;
      if (buf_pop) buf_rd_ptr <= buf_rd_ptr + 1'b1;
      if (lookup_valid && rq_full && !rq_pop) lookup_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= O_IDLE;
    else       state <= state_next;
  end

  // A packet is only started once its result and at least one word are both present;
  // underruns inside a packet simply stall in the current state.
  always_comb begin
    state_next = state;
    buf_pop    = 1'b0;
    rq_pop     = 1'b0;
    emit       = 1'b0;
    case (state)
      O_IDLE: begin
        if (!rq_empty && !buf_empty) begin
          rq_pop     = 1'b1;
          state_next = rq_head[RES_W-1] ? O_DROP : O_FWD;
        end
      end
      O_FWD: begin
        if (out_rdy && !buf_empty) begin
          buf_pop = 1'b1;
          emit    = 1'b1;
          if (head_eop) state_next = O_IDLE;
        end
      end
      O_DROP: begin
        if (!buf_empty) begin
          buf_pop = 1'b1;
          if (head_eop) state_next = O_IDLE;
        end
      end
      default: state_next = O_IDLE;
    endcase
  end

  assign patch = emit && (head_ctrl == IOQ_CTRL) && !ioq_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_wr         <= 1'b0;
      out_data       <= '0;
      out_ctrl       <= '0;
      cur_dst        <= '0;
      ioq_done       <= 1'b0;
      pkts_forwarded <= '0;
      pkts_dropped   <= '0;
    end else begin
      out_wr <= emit;
      if (emit) begin
        out_ctrl <= head_ctrl;
        out_data <= patch ? {16'(cur_dst), head_data[DATA_WIDTH-17:0]} : head_data;
      end
      if (rq_pop) begin
        cur_dst  <= rq_head[NUM_OUTPUT_QUEUES-1:0];
        ioq_done <= 1'b0;
      end else if (patch) begin
        ioq_done <= 1'b1;
      end
      if (pop_eop && state == O_FWD)  pkts_forwarded <= pkts_forwarded + 32'd1;
      if (pop_eop && state == O_DROP) pkts_dropped   <= pkts_dropped + 32'd1;
    end
  end

endmodule

// File: tb/tb_lookup_hold_queue.sv
// Testbench for lookup_hold_queue: directed and randomized packets checked against a
// packet-level model of forward/drop/IOQ-patch behaviour.
`timescale 1ns/1ps
module tb_lookup_hold_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy = 1'b1;
  logic        lookup_valid;
  logic [7:0]  lookup_dst_ports;
  logic        lookup_drop;
  logic        lookup_overflow;
  logic [31:0] pkts_forwarded;
  logic [31:0] pkts_dropped;

  always #5 clk = ~clk;

  lookup_hold_queue dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .lookup_valid(lookup_valid), .lookup_dst_ports(lookup_dst_ports), .lookup_drop(lookup_drop),
    .lookup_overflow(lookup_overflow), .pkts_forwarded(pkts_forwarded), .pkts_dropped(pkts_dropped)
  );

  int checkCount = 0;
  int errCount   = 0;
  int cyc        = 0;
  int rdyMode    = 0;
  bit gapMode    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: packets and results pair strictly in order; forwarded words
  // (with the first IOQ header patched) go to the expected output queue.
  logic [71:0] pendWords[$];
  int          pendLens[$];
  logic [8:0]  pendRes[$];
  logic [71:0] expQ[$];
  int          expFwd  = 0;
  int          expDrop = 0;

  function automatic void modelResolve();
    int          len;
    logic [8:0]  res;
    logic [71:0] w;
    bit          ioqSeen;
    while (pendLens.size() > 0 && pendRes.size() > 0) begin
      len = pendLens.pop_front();
      res = pendRes.pop_front();
      ioqSeen = 0;
      for (int i = 0; i < len; i++) begin
        w = pendWords.pop_front();
        if (!res[8]) begin
          if (!ioqSeen && w[71:64] == 8'hFF) begin
            w[63:48] = {8'h00, res[7:0]};
            ioqSeen = 1;
          end
          expQ.push_back(w);
        end
      end
      if (res[8]) expDrop++;
      else        expFwd++;
    end
  endfunction

  function automatic void modelFlush();
    pendWords.delete();
    pendLens.delete();
    pendRes.delete();
    expQ.delete();
    expFwd  = 0;
    expDrop = 0;
  endfunction

  int          outCount     = 0;
  int          firstOutCyc  = -1;
  logic [71:0] firstOutWord = '0;
  logic [71:0] monGot;

  always @(negedge clk) begin
    if (out_wr === 1'b1) begin
      monGot = {out_ctrl, out_data};
      outCount++;
      if (firstOutCyc < 0) begin
        firstOutCyc  = cyc;
        firstOutWord = monGot;
      end
      if (expQ.size() == 0) checkOutput("out_extra_word", 72'(expQ.size()), 72'd1);
      else                  checkOutput("out_word", monGot, expQ.pop_front());
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdyMode)
      0:       out_rdy = 1'b1;
      1:       out_rdy = ~out_rdy;
      default: out_rdy = ($urandom_range(0, 9) < 7);
    endcase
  end

  logic [71:0] pkt[$];
  int          lastDriveCyc = 0;
  int          firstInCyc   = 0;

  task automatic buildPacket(input int nPayload, input bit withIoq, input bit extraHdr);
    pkt.delete();
    if (extraHdr) pkt.push_back({8'h40, $urandom, $urandom});
    if (withIoq)  pkt.push_back({8'hFF, $urandom, $urandom});
    for (int i = 0; i < nPayload; i++) pkt.push_back({8'h00, $urandom, $urandom});
    pkt.push_back({8'($urandom_range(1, 127)), $urandom, $urandom});
  endtask

  task automatic sendWord(input logic [71:0] w);
    int waitCycles = 0;
    while (!in_rdy && waitCycles < 3000) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    if (!in_rdy) checkOutput("in_rdy_timeout", 72'(in_rdy), 72'd1);
    in_wr   = 1'b1;
    in_ctrl = w[71:64];
    in_data = w[63:0];
    lastDriveCyc = cyc;
    @(posedge clk); #1;
    in_wr = 1'b0;
  endtask

  task automatic sendResult(input bit drop, input logic [7:0] dst, input bit toModel);
    lookup_valid     = 1'b1;
    lookup_drop      = drop;
    lookup_dst_ports = dst;
    @(posedge clk); #1;
    lookup_valid = 1'b0;
    if (toModel) begin
      pendRes.push_back({drop, dst});
      modelResolve();
    end
  endtask

  // resWhen: 0 before first word, 1 after a random word, 2 after EOP, 3 not sent
  task automatic applyStimulus(input int resWhen, input bit drop, input logic [7:0] dst);
    int midIdx;
    foreach (pkt[i]) pendWords.push_back(pkt[i]);
    pendLens.push_back(pkt.size());
    midIdx = $urandom_range(0, pkt.size() - 1);
    if (resWhen == 0) sendResult(drop, dst, 1);
    foreach (pkt[i]) begin
      if (gapMode && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      sendWord(pkt[i]);
      if (i == 0) firstInCyc = lastDriveCyc;
      if (resWhen == 1 && i == midIdx) sendResult(drop, dst, 1);
    end
    if (resWhen == 2) sendResult(drop, dst, 1);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (expQ.size() != 0) checkOutput("drain_timeout", 72'(expQ.size()), 72'd0);
    repeat (40) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  int outBase;

  initial begin
    reset = 1'b1; in_wr = 1'b0; in_data = '0; in_ctrl = '0;
    lookup_valid = 1'b0; lookup_drop = 1'b0; lookup_dst_ports = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_rdy", 72'(in_rdy), 72'd0);
    checkOutput("rst_out_wr", 72'(out_wr), 72'd0);
    checkOutput("rst_out_data", {out_ctrl, out_data}, 72'd0);
    checkOutput("rst_overflow", 72'(lookup_overflow), 72'd0);
    checkOutput("rst_counters", {8'h00, pkts_forwarded, pkts_dropped}, 72'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_release_in_rdy", 72'(in_rdy), 72'd1);

    // Single 8-word packet with the result queued first
    pkt.delete();
    pkt.push_back({8'hFF, 64'h0000_0040_0000_0040});
    for (int i = 0; i < 6; i++) pkt.push_back({8'h00, 32'(i), $urandom});
    pkt.push_back({8'h01, 64'hDEAD_BEEF_0000_0007});
    firstOutCyc = -1;
    outBase = outCount;
    applyStimulus(0, 1'b0, 8'h04);
    waitDrain();
    checkOutput("t1_latency", 72'(firstOutCyc - firstInCyc), 72'd3);
    checkOutput("t1_ioq_word", firstOutWord, {8'hFF, 64'h0004_0040_0000_0040});
    checkOutput("t1_word_count", 72'(outCount - outBase), 72'd8);
    checkOutput("t1_forwarded", 72'(pkts_forwarded), 72'd1);

    // Three back-to-back packets: forward, drop, forward
    buildPacket(3, 1, 0); applyStimulus(2, 1'b0, 8'h01);
    buildPacket(4, 1, 1); applyStimulus(2, 1'b1, 8'h00);
    buildPacket(2, 1, 0); applyStimulus(2, 1'b0, 8'h80);
    waitDrain();
    checkOutput("t2_dropped", 72'(pkts_dropped), 72'd1);
    checkOutput("t2_forwarded", 72'(pkts_forwarded), 72'd3);

    // Alternating out_rdy
    rdyMode = 1;
    buildPacket(8, 1, 1);
    outBase = outCount;
    applyStimulus(2, 1'b0, 8'h02);
    waitDrain();
    rdyMode = 0;
    checkOutput("t3_word_count", 72'(outCount - outBase), 72'd11);
    checkOutput("t3_forwarded", 72'(pkts_forwarded), 72'd4);

    // Randomized packets, results, gaps and backpressure
    rdyMode = 2;
    gapMode = 1;
    for (int p = 0; p < 30; p++) begin
      buildPacket($urandom_range(1, 8), ($urandom_range(0, 9) != 0), $urandom_range(0, 1));
      applyStimulus($urandom_range(1, 2), ($urandom_range(0, 3) == 0), 8'($urandom));
    end
    waitDrain();
    rdyMode = 0;
    gapMode = 0;
    checkOutput("rand_forwarded", 72'(pkts_forwarded), 72'(expFwd));
    checkOutput("rand_dropped", 72'(pkts_dropped), 72'(expDrop));

    // Fill: 16 packets in flight block the 17th
    for (int p = 0; p < 16; p++) begin
      buildPacket(1, 1, 0);
      applyStimulus(3, 1'b0, 8'h00);
    end
    checkOutput("fill_in_rdy", 72'(in_rdy), 72'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("fill_in_rdy_hold", 72'(in_rdy), 72'd0);
    for (int r = 0; r < 16; r++) sendResult(1'b0, 8'(1 << (r % 8)), 1);
    buildPacket(1, 1, 0);
    applyStimulus(2, 1'b0, 8'h10);
    waitDrain();
    checkOutput("fill_forwarded", 72'(pkts_forwarded), 72'(expFwd));
    checkOutput("fill_in_rdy_after", 72'(in_rdy), 72'd1);

    // Result queue overflow with no packets
    for (int r = 0; r < 17; r++) begin
      sendResult(1'b0, 8'h01, 0);
      if (r == 15) checkOutput("ovf_before", 72'(lookup_overflow), 72'd0);
    end
    checkOutput("ovf_set", 72'(lookup_overflow), 72'd1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("ovf_sticky", 72'(lookup_overflow), 72'd1);

    reset = 1'b1;
    @(posedge clk); #1;
    modelFlush();
    checkOutput("rst2_in_rdy", 72'(in_rdy), 72'd0);
    checkOutput("rst2_overflow", 72'(lookup_overflow), 72'd0);
    checkOutput("rst2_counters", {8'h00, pkts_forwarded, pkts_dropped}, 72'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of forwarding
    buildPacket(6, 1, 0);
    applyStimulus(0, 1'b0, 8'h08);
    checkOutput("rstmid_pre_out_wr", 72'(out_wr), 72'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    modelFlush();
    checkOutput("rstmid_out_wr", 72'(out_wr), 72'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("rstmid_counters", {8'h00, pkts_forwarded, pkts_dropped}, 72'd0);
    buildPacket(2, 1, 0);
    outBase = outCount;
    applyStimulus(0, 1'b0, 8'h20);
    waitDrain();
    checkOutput("rstmid_word_count", 72'(outCount - outBase), 72'd4);
    checkOutput("rstmid_forwarded", 72'(pkts_forwarded), 72'd1);
    checkOutput("rstmid_dropped", 72'(pkts_dropped), 72'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
